wb_lsu_master: RTL and testbench
================================

Name: wb_lsu_master

Overview:
Wishbone initiator for the core data port; the master-side counterpart of the dual-port wishbone RAM's data slave. It accepts one load/store request at a time from the core and checks alignment. It then runs a single classic wishbone cycle with byte-lane steering, extracts and sign/zero-extends read data, and returns a one-cycle response. Bus errors and unresponsive slaves (timeout) are reported as errors.

Parameters:
TIMEOUT, 256, max cycles cyc_o may stay high without ack/err before the cycle is aborted with error (>=2)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, asynchronous, active-high
req_valid_i  input  1  core request valid
req_ready_o  output  1  master can accept request (high only in IDLE)
req_addr_i  input  32  byte address
req_we_i  input  1  1=store, 0=load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
req_signed_i  input  1  loads: 1 sign-extend, 0 zero-extend
req_wdata_i  input  32  store data, right-aligned
rsp_valid_o  output  1  one-cycle response pulse
rsp_rdata_o  output  32  extended load data (0 for stores/errors)
rsp_err_o  output  1  bus error or timeout, valid with rsp_valid_o
rsp_misaligned_o  output  1  alignment/size fault, valid with rsp_valid_o
wbm_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
wbm_dat_o  output  32  steered write data
wbm_sel_o  output  4  byte enables
wbm_cyc_o  output  1  cycle
wbm_stb_o  output  1  strobe
wbm_we_o  output  1  write enable
wbm_dat_i  input  32  read data
wbm_ack_i  input  1  acknowledge (may be combinational, same cycle as stb)
wbm_err_i  input  1  bus error

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0 except req_ready_o=1, timeout counter=0. A cycle in flight is dropped immediately.
- States: IDLE, BUS, DONE. All outputs are registered except req_ready_o = (state==IDLE).
- IDLE: on req_valid_i at edge E:
  - Misaligned case (size=11; half with addr[0]=1; word with addr[1:0]!=0): no bus cycle; go to DONE with misaligned=1, err=0, rdata=0.
  - Otherwise: latch addr, size, signed, we and steered data; assert cyc/stb/we; go to BUS.
- Steering:
  - byte: sel=0001<<addr[1:0], dat={4{wdata[7:0]}}
  - half: sel=0011<<addr[1:0], dat={2{wdata[15:0]}}
  - word: sel=1111, dat=wdata
  - sel is driven for reads too.
- BUS: cyc/stb/addr/sel/dat/we are held stable; the counter increments each cycle.
  - err_i sampled high: drop cyc/stb, rsp_err=1, rdata=0. If err_i and ack_i are high together, err wins.
  - Otherwise ack_i sampled high: drop cyc/stb. For loads, rdata=(dat_i>>(8*addr[1:0])) truncated to size and extended per signed; for stores, rdata=0.
  - Counter reaches TIMEOUT-1 with neither ack nor err: drop cyc/stb, rsp_err=1.
  - All three exits go to DONE.
- DONE: rsp_valid_o=1 for exactly one cycle; cyc/stb=0; go to IDLE. Response fields stay held until the next response.
- Latency with same-cycle ack: accept edge E; cyc high in cycle E+1; ack sampled at edge E+2; rsp_valid high in cycle E+2..E+3; req_ready high again from E+3. This is 3 cycles request-to-request.
- Misaligned requests take 2 cycles (IDLE->DONE->IDLE) and never assert cyc.
- Only one outstanding transaction; req_valid_i is ignored outside IDLE.
- ack/err arriving while cyc=0 is ignored.

Test Plan:
- Word load: the slave holds 0x8000_0FF0 at 0x100. Request load word at 0x100 → wbm_sel=1111, cyc high one cycle, then rsp_valid with rdata=0x8000_0FF0, err=0, misaligned=0.
- Signed/unsigned byte: same memory, load byte at 0x103. signed=1 gives rdata=0xFFFF_FF80 with sel=1000; signed=0 gives 0x0000_0080.
- Half store: store half 0xBEEF at 0x202 → sel=1100, dat=0xBEEF_BEEF, we=1. A word readback at 0x200 shows 0xBEEF_xxxx with the low half unchanged.
- Misaligned: load word at 0x101 → cyc never asserted; rsp_valid after 1 cycle with misaligned=1, rdata=0. size=11 gives the same result.
- Error/timeout: err_i asserted together with ack_i → rsp_err=1, rdata=0. With TIMEOUT=4 and a silent slave, cyc stays high exactly 4 cycles, then rsp_err=1.
- Reset mid-cycle: assert rst_i between clock edges while in BUS → cyc/stb drop without waiting for a clock edge, no rsp_valid is produced, and req_ready=1 after reset.

Source files
------------

// File: rtl/wb_lsu_master.sv
`timescale 1ns/1ps
// wb_lsu_master
// Wishbone classic initiator for the core data port. Takes one load/store
// at a time, rejects misaligned or illegal-size requests without touching
// the bus, runs one classic cycle with byte-lane steering, extracts and
// extends load data, and returns a one-cycle response. A slave that never
// answers is cut off after TIMEOUT cycles and reported as an error.
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-high reset
//   req_*               core request (valid/ready handshake, accepted in IDLE)
//   rsp_*               one-cycle response pulse with held data/err/misaligned
//   wbm_* outputs       registered wishbone master signals
//   wbm_dat_i/ack_i/err_i  slave response (ack may be combinational)
module wb_lsu_master #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_misaligned_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] COUNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t          state, next_state;
  logic [1:0]      lane, size;
  logic            sign_ext;
  logic [CW-1:0]   count;

  logic            misaligned;
  logic [3:0]      sel;
  logic [31:0]     steered;
  logic [31:0]     shifted;
  logic [31:0]     load_data;
  logic            bus_err, bus_ack, bus_timeout;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid_i) next_state = misaligned ? DONE : BUS;
      BUS:  if (bus_err || bus_ack || bus_timeout) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    req_ready_o = (state == IDLE);

    misaligned = 1'b0;
    sel        = 4'b0000;
    steered    = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        sel     = 4'b0001 << req_addr_i[1:0];
        steered = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr_i[0];
        sel        = 4'b0011 << req_addr_i[1:0];
        steered    = {2{req_wdata_i[15:0]}};
      end
      2'b10: begin
        misaligned = (req_addr_i[1:0] != 2'b00);
        sel        = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase

    // Move the addressed lane down to bit 0, then truncate and extend.
    shifted = wbm_dat_i >> {lane, 3'b000};
    case (size)
      2'b00:   load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase

    // Error has priority over ack; the timeout only fires on a silent slave.
    bus_err     = (state == BUS) && wbm_err_i;
    bus_ack     = (state == BUS) && !wbm_err_i && wbm_ack_i;
    bus_timeout = (state == BUS) && !wbm_err_i && !wbm_ack_i && (count == COUNT_MAX);
  end

  // Registered bus and response outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbm_addr_o       <= '0;
      wbm_dat_o        <= '0;
      wbm_sel_o        <= '0;
      wbm_cyc_o        <= 1'b0;
      wbm_stb_o        <= 1'b0;
      wbm_we_o         <= 1'b0;
      lane             <= '0;
      size             <= '0;
      sign_ext         <= 1'b0;
      count            <= '0;
      rsp_valid_o      <= 1'b0;
      rsp_rdata_o      <= '0;
      rsp_err_o        <= 1'b0;
      rsp_misaligned_o <= 1'b0;
    end else begin
      rsp_valid_o <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (misaligned) begin
              rsp_rdata_o      <= '0;
              rsp_err_o        <= 1'b0;
              rsp_misaligned_o <= 1'b1;
            end else begin
              wbm_addr_o <= {req_addr_i[31:2], 2'b00};
              wbm_dat_o  <= steered;
              wbm_sel_o  <= sel;
              wbm_we_o   <= req_we_i;
              wbm_cyc_o  <= 1'b1;
              wbm_stb_o  <= 1'b1;
              lane       <= req_addr_i[1:0];
              size       <= req_size_i;
              sign_ext   <= req_signed_i;
              count      <= '0;
            end
          end
        end
        BUS: begin
          if (bus_err || bus_ack || bus_timeout) begin
            wbm_cyc_o        <= 1'b0;
            wbm_stb_o        <= 1'b0;
            rsp_err_o        <= bus_err || bus_timeout;
            rsp_misaligned_o <= 1'b0;
            rsp_rdata_o      <= (bus_ack && !wbm_we_o) ? load_data : '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
`timescale 1ns/1ps
// Self-checking bench for wb_lsu_master: a behavioural wishbone slave with
// configurable wait states / error / silence, and a byte-addressed reference
// memory that predicts every response from the request alone.
module tb_wb_lsu_master;

  localparam int TIMEOUT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = '0;
  logic        req_signed_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_misaligned_o;
  logic [31:0] wbm_addr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  int n_checks = 0;
  int n_fail   = 0;

  wb_lsu_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_signed_i(req_signed_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_misaligned_o(rsp_misaligned_o),
    .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- behavioural slave ----------------
  typedef enum {S_NORMAL, S_ERR_ACK, S_SILENT} slave_mode_t;
  slave_mode_t mode = S_NORMAL;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        stray_ack = 1'b0;
  logic [31:0] slave_mem [256];
  logic        hit;

  assign hit       = wbm_cyc_o && wbm_stb_o && (wait_cnt == ack_delay);
  assign wbm_ack_i = stray_ack || (hit && mode != S_SILENT);
  assign wbm_err_i = hit && mode == S_ERR_ACK;
  assign wbm_dat_i = slave_mem[wbm_addr_o[9:2]];

  always @(posedge clk_i) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (hit && mode == S_NORMAL && wbm_we_o)
      for (int b = 0; b < 4; b++)
        if (wbm_sel_o[b]) slave_mem[wbm_addr_o[9:2]][8*b +: 8] = wbm_dat_o[8*b +: 8];
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];

  function automatic logic ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] ref_sel(input logic [31:0] a, input logic [1:0] sz);
    int nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    logic [3:0] s = '0;
    for (int i = 0; i < nbytes; i++) s[(a + i) % 4] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_dat(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] v = '0;
    int nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < nbytes; i++)
      v = v + (((ref_mem[(a >> 2) % 256] >> (8 * ((a + i) % 4))) & 32'hFF) << (8 * i));
    if (sg && nbytes < 4 && v[8*nbytes-1]) v = v - (32'd1 << (8 * nbytes));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < nbytes; i++)
      ref_mem[(a >> 2) % 256][8*((a + i) % 4) +: 8] = wd[8*i +: 8];
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    slave_mem[idx] = v;
    ref_mem[idx]   = v;
  endtask

  // ---------------- request driver / observer ----------------
  typedef struct {
    logic ready0; logic got; int lat; int cyc_n;
    logic [3:0] sel; logic [31:0] dat; logic we; logic [31:0] addr; logic stable;
    logic [31:0] rdata; logic err; logic mis;
    logic valid_after; logic ready_after; logic [31:0] rdata_after;
  } obs_t;

  task automatic run_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd, output obs_t o);
    o = '{default: '0};
    o.stable = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = a; req_we_i = we;
    req_size_i = sz; req_signed_i = sg; req_wdata_i = wd;
    o.ready0 = req_ready_o;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int n = 0; n < 20 && !o.got; n++) begin
      if (wbm_cyc_o) begin
        if (o.cyc_n == 0) begin
          o.sel = wbm_sel_o; o.dat = wbm_dat_o; o.we = wbm_we_o; o.addr = wbm_addr_o;
        end else if (o.sel !== wbm_sel_o || o.dat !== wbm_dat_o || o.we !== wbm_we_o ||
                     o.addr !== wbm_addr_o || wbm_stb_o !== 1'b1) begin
          o.stable = 1'b0;
        end
        o.cyc_n++;
      end
      if (rsp_valid_o) begin
        o.got = 1'b1; o.lat = n;
        o.rdata = rsp_rdata_o; o.err = rsp_err_o; o.mis = rsp_misaligned_o;
      end else begin
        @(negedge clk_i);
      end
    end
    @(negedge clk_i);
    o.valid_after = rsp_valid_o;
    o.ready_after = req_ready_o;
    o.rdata_after = rsp_rdata_o;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    n_checks++; if (wbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset cyc: got %b want 0", wbm_cyc_o); end
    n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b want 1", req_ready_o); end
    n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid_o); end
    n_checks++; if (rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset rdata: got %h want 0", rsp_rdata_o); end
    n_checks++; if ({wbm_stb_o, wbm_we_o, wbm_sel_o} !== 6'b0) begin n_fail++; $display("FAIL reset stb/we/sel: got %b want 0", {wbm_stb_o, wbm_we_o, wbm_sel_o}); end
  endtask

  task automatic test_word_load;
    obs_t o;
    mode = S_NORMAL; ack_delay = 0;
    set_word(32'h100 >> 2, 32'h8000_0FF0);
    run_req(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, o);
    n_checks++; if (o.ready0 !== 1'b1) begin n_fail++; $display("FAIL word_load ready: got %b want 1", o.ready0); end
    n_checks++; if (o.sel !== 4'b1111) begin n_fail++; $display("FAIL word_load sel: got %b want 1111", o.sel); end
    n_checks++; if (o.addr !== 32'h100) begin n_fail++; $display("FAIL word_load addr: got %h want 100", o.addr); end
    n_checks++; if (o.cyc_n !== 1) begin n_fail++; $display("FAIL word_load cyc_cycles: got %0d want 1", o.cyc_n); end
    n_checks++; if (o.got !== 1'b1 || o.lat !== 1) begin n_fail++; $display("FAIL word_load latency: got %b/%0d want 1/1", o.got, o.lat); end
    n_checks++; if (o.rdata !== 32'h8000_0FF0) begin n_fail++; $display("FAIL word_load rdata: got %h want 80000ff0", o.rdata); end
    n_checks++; if ({o.err, o.mis} !== 2'b00) begin n_fail++; $display("FAIL word_load err/mis: got %b want 00", {o.err, o.mis}); end
    n_checks++; if (o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin n_fail++; $display("FAIL word_load pulse: got valid=%b ready=%b want 0/1", o.valid_after, o.ready_after); end
    n_checks++; if (o.rdata_after !== 32'h8000_0FF0) begin n_fail++; $display("FAIL word_load hold: got %h want 80000ff0", o.rdata_after); end
  endtask

  task automatic test_byte_load;
    obs_t o;
    run_req(32'h103, 1'b0, 2'd0, 1'b1, 32'h0, o);
    n_checks++; if (o.rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_signed rdata: got %h want ffffff80", o.rdata); end
    n_checks++; if (o.sel !== 4'b1000) begin n_fail++; $display("FAIL byte_signed sel: got %b want 1000", o.sel); end
    run_req(32'h103, 1'b0, 2'd0, 1'b0, 32'h0, o);
    n_checks++; if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_unsigned rdata: got %h want 00000080", o.rdata); end
  endtask

  task automatic test_half_store;
    obs_t o;
    logic [31:0] prior = $urandom;
    set_word(32'h200 >> 2, prior);
    run_req(32'h202, 1'b1, 2'd1, 1'b0, 32'h5A5A_BEEF, o);
    ref_store(32'h202, 2'd1, 32'h5A5A_BEEF);
    n_checks++; if (o.sel !== 4'b1100) begin n_fail++; $display("FAIL half_store sel: got %b want 1100", o.sel); end
    n_checks++; if (o.dat !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL half_store dat: got %h want beefbeef", o.dat); end
    n_checks++; if (o.we !== 1'b1) begin n_fail++; $display("FAIL half_store we: got %b want 1", o.we); end
    n_checks++; if (o.rdata !== 32'h0 || o.err !== 1'b0) begin n_fail++; $display("FAIL half_store rsp: got rdata=%h err=%b want 0/0", o.rdata, o.err); end
    run_req(32'h200, 1'b0, 2'd2, 1'b0, 32'h0, o);
    n_checks++; if (o.rdata !== {16'hBEEF, prior[15:0]}) begin n_fail++; $display("FAIL half_readback rdata: got %h want %h", o.rdata, {16'hBEEF, prior[15:0]}); end
  endtask

  task automatic test_misaligned;
    obs_t o;
    logic [31:0] addrs [3] = '{32'h101, 32'h100, 32'h103};
    logic [1:0]  sizes [3] = '{2'd2, 2'd3, 2'd1};
    for (int i = 0; i < 3; i++) begin
      run_req(addrs[i], 1'b0, sizes[i], 1'b0, 32'h0, o);
      n_checks++;
      if (o.cyc_n !== 0 || o.got !== 1'b1 || o.lat !== 0 || o.mis !== 1'b1 || o.err !== 1'b0 ||
          o.rdata !== 32'h0 || o.ready_after !== 1'b1) begin
        n_fail++;
        $display("FAIL misaligned[%0d]: got cyc=%0d got=%b lat=%0d mis=%b err=%b rdata=%h ready=%b want 0/1/0/1/0/0/1",
                 i, o.cyc_n, o.got, o.lat, o.mis, o.err, o.rdata, o.ready_after);
      end
    end
  endtask

  task automatic test_err;
    obs_t o;
    mode = S_ERR_ACK; ack_delay = 1;
    run_req(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, o);
    mode = S_NORMAL;
    n_checks++; if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.mis !== 1'b0) begin n_fail++; $display("FAIL err_ack rsp: got err=%b rdata=%h mis=%b want 1/0/0", o.err, o.rdata, o.mis); end
    n_checks++; if (o.cyc_n !== 2) begin n_fail++; $display("FAIL err_ack cyc_cycles: got %0d want 2", o.cyc_n); end
  endtask

  task automatic test_timeout;
    obs_t o;
    mode = S_SILENT;
    run_req(32'h104, 1'b0, 2'd2, 1'b0, 32'h0, o);
    mode = S_NORMAL;
    n_checks++; if (o.cyc_n !== TIMEOUT) begin n_fail++; $display("FAIL timeout cyc_cycles: got %0d want %0d", o.cyc_n, TIMEOUT); end
    n_checks++; if (o.got !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL timeout rsp: got valid=%b err=%b rdata=%h want 1/1/0", o.got, o.err, o.rdata); end
    n_checks++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL timeout stable: got %b want 1", o.stable); end
  endtask

  task automatic test_stray_ack;
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (rsp_valid_o !== 1'b0 || wbm_cyc_o !== 1'b0 || req_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL stray_ack[%0d]: got valid=%b cyc=%b ready=%b want 0/0/1", i, rsp_valid_o, wbm_cyc_o, req_ready_o);
      end
    end
    stray_ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic saw_rsp = 1'b0;
    mode = S_SILENT;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 32'h108; req_we_i = 1'b0; req_size_i = 2'd2;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (wbm_cyc_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid setup cyc: got %b want 1", wbm_cyc_o); end
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid async drop: got cyc=%b stb=%b want 0/0", wbm_cyc_o, wbm_stb_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    mode = S_NORMAL;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid_o) saw_rsp = 1'b1;
      @(negedge clk_i);
    end
    n_checks++; if (saw_rsp !== 1'b0) begin n_fail++; $display("FAIL reset_mid rsp_valid: got %b want 0", saw_rsp); end
    n_checks++; if (req_ready_o !== 1'b1 || wbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid idle: got ready=%b cyc=%b want 1/0", req_ready_o, wbm_cyc_o); end
  endtask

  task automatic test_random;
    obs_t o;
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a  = {$urandom_range(0, 15), 18'h0, 10'($urandom)};
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic        we = 1'($urandom);
      logic        sg = 1'($urandom);
      logic [31:0] wd = $urandom;
      logic        mis;
      logic [31:0] exp_rd;
      int          d = $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & ~32'd1;
        if (sz == 2'd2) a = a & ~32'd3;
      end
      mode = S_NORMAL; ack_delay = d;
      mis = ref_misaligned(a, sz);
      exp_rd = (mis || we) ? 32'h0 : ref_load(a, sz, sg);
      run_req(a, we, sz, sg, wd, o);
      n_checks++;
      if (mis) begin
        if (o.cyc_n !== 0 || o.got !== 1'b1 || o.lat !== 0 || o.mis !== 1'b1 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL random[%0d] misaligned a=%h sz=%0d: got cyc=%0d lat=%0d mis=%b err=%b rdata=%h want 0/0/1/0/0",
                   k, a, sz, o.cyc_n, o.lat, o.mis, o.err, o.rdata);
        end
      end else begin
        if (o.cyc_n !== d + 1 || o.got !== 1'b1 || o.lat !== d + 1 || o.sel !== ref_sel(a, sz) ||
            o.dat !== ref_dat(wd, sz) || o.we !== we || o.addr !== (a & ~32'd3) || o.stable !== 1'b1 ||
            o.rdata !== exp_rd || o.err !== 1'b0 || o.mis !== 1'b0 || o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
          n_fail++;
          $display("FAIL random[%0d] a=%h we=%b sz=%0d sg=%b: got cyc=%0d lat=%0d sel=%b dat=%h addr=%h rdata=%h err=%b want cyc=%0d sel=%b dat=%h addr=%h rdata=%h err=0",
                   k, a, we, sz, sg, o.cyc_n, o.lat, o.sel, o.dat, o.addr, o.rdata, o.err,
                   d + 1, ref_sel(a, sz), ref_dat(wd, sz), a & ~32'd3, exp_rd);
        end
        if (we) ref_store(a, sz, wd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    #1;
    n_checks++; if (wbm_cyc_o !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_held: got cyc=%b ready=%b want 0/1", wbm_cyc_o, req_ready_o); end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_err();
    test_timeout();
    test_stray_ack();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
